// File: rtl/hynoc_pkg.sv
// hynoc_pkg: shared flit-format helpers and arbiter FSM encodings for HyNoC routers
package hynoc_pkg;
   localparam int DEFAULT_PAYLOAD_WIDTH = 32;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_t;
   function automatic int flit_width(input int payload_width);
      return payload_width + 1;
   endfunction
   function automatic int stop_bit(input int flit_w);
      return flit_w - 1;
   endfunction
endpackage

// File: rtl/hynoc_rr_pick.sv
// hynoc_rr_pick: combinational rotating-priority picker, first request above last wins
module hynoc_rr_pick #(
   parameter int N  = 4,
   parameter int LW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  pick,
   output logic [LW-1:0] idx
);
   logic found;
   always_comb begin
      found = 1'b0;
      idx = '0;
      for (int k = 1; k <= N; k++)
         if (!found && req[(int'(last) + k) % N]) begin
            found = 1'b1;
            idx = LW'((int'(last) + k) % N);
         end
      pick = {{(N-1){1'b0}}, found} << idx;
   end
endmodule

// File: rtl/hynoc_egress_pkt_arbiter.sv
// hynoc_egress_pkt_arbiter: packet-level round-robin sharing one egress FIFO write port
module hynoc_egress_pkt_arbiter
   import hynoc_pkg::*;
#(
   parameter int NB_PORTS        = 5,
   parameter int LOG2_FIFO_DEPTH = 5,
   parameter int PAYLOAD_WIDTH   = DEFAULT_PAYLOAD_WIDTH,
   parameter int FLIT_WIDTH      = flit_width(PAYLOAD_WIDTH),
   parameter int AFULL_MARGIN    = 4,
   localparam int NB_REQ         = NB_PORTS - 1
) (
   input  logic                         router_clk,
   input  logic                         router_srst,
   input  logic [NB_REQ-1:0]            from_ingress_request,
   input  logic [NB_REQ-1:0]            from_ingress_write,
   input  logic [NB_REQ*FLIT_WIDTH-1:0] from_ingress_data,
   input  logic [LOG2_FIFO_DEPTH:0]     wlevel,
   output logic [NB_REQ-1:0]            to_ingress_grant,
   output logic [NB_REQ-1:0]            to_ingress_afull,
   output logic                         wen,
   output logic [FLIT_WIDTH-1:0]        wdata,
   output logic                         busy,
   output logic                         err_write
);
   localparam int LW = $clog2(NB_REQ);
   localparam int STOP = stop_bit(FLIT_WIDTH);
   localparam logic [LOG2_FIFO_DEPTH:0] THRESH = (LOG2_FIFO_DEPTH+1)'((2 ** LOG2_FIFO_DEPTH) - AFULL_MARGIN);
   arb_state_t state;
   logic [LW-1:0] last, g, pick_idx;
   logic [NB_REQ-1:0] pick;
   logic [FLIT_WIDTH-1:0] flit_g;
   hynoc_rr_pick #(.N(NB_REQ), .LW(LW)) u_pick (
      .req  (from_ingress_request),
      .last (last),
      .pick (pick),
      .idx  (pick_idx)
   );
   assign flit_g = from_ingress_data[int'(g)*FLIT_WIDTH +: FLIT_WIDTH];
   // grant is zero in IDLE, so any write outside the held grant is a stray write
   always_ff @(posedge router_clk) begin
      if (router_srst) begin
         state <= IDLE;
         last <= LW'(NB_REQ - 1);
         g <= '0;
         to_ingress_grant <= '0;
         to_ingress_afull <= '0;
         wen <= 1'b0;
         wdata <= '0;
         busy <= 1'b0;
         err_write <= 1'b0;
      end else begin
         to_ingress_afull <= {NB_REQ{wlevel >= THRESH}};
         err_write <= err_write | (|(from_ingress_write & ~to_ingress_grant));
         wen <= 1'b0;
         if (state == IDLE) begin
            if (|from_ingress_request) begin
               to_ingress_grant <= pick;
               g <= pick_idx;
               state <= LOCKED;
               busy <= 1'b1;
            end
         end else if (from_ingress_write[g]) begin
            wen <= 1'b1;
            wdata <= flit_g;
            if (flit_g[STOP]) begin
               to_ingress_grant <= '0;
               last <= g;
               state <= IDLE;
               busy <= 1'b0;
            end
         end
      end
   end
endmodule
